// File: rtl/pipo_pipe.sv
// Elastic parallel-in/parallel-out register pipeline: per-stage valid bits,
// bubble collapsing, synchronous flush and a count of held words.
module pipo_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] moveStage;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             acceptRaw;
  logic             inFire;
  logic             outFire;

  // Walk back from the output: a stage advances when the stage below it is empty or itself advancing.
  always_comb begin
    logic accept;
    accept    = out_ready;
    moveStage = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      moveStage[i] = valid_q[i] && accept;
      accept       = !valid_q[i] || moveStage[i];
    end
    acceptRaw = accept;
  end

  assign in_ready  = !flush && acceptRaw;
  assign inFire    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  always_comb begin
    valid_d    = '0;
    valid_d[0] = inFire || (valid_q[0] && !moveStage[0]);
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = moveStage[i-1] || (valid_q[i] && !moveStage[i]);
    end
    count_d = count_q;
    if (inFire && !outFire) begin
      count_d = count_q + CW'(1);
    end else if (outFire && !inFire) begin
      count_d = count_q - CW'(1);
    end
  end

  // Flush drops every held word but leaves the data registers untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (inFire) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (moveStage[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipo_pipe.sv
// Bench for pipo_pipe: directed scenarios plus a randomized phase, all checked
// by a negedge monitor against a FIFO-level model of the held words.
module tb_pipo_pipe;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int               checkCount = 0;
  int               passCount  = 0;
  int               cycleCnt   = 0;
  int               startCycle = 0;
  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] lastOut = '0;
  int               outCycles[$];

  pipo_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
  endtask

  task automatic recordFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s: got no event, expected it within the cycle budget (cycle %0d)", name, cycleCnt);
  endtask

  // Model: the pipeline is an ordered store of at most DEPTH words; any free slot, or a draining output, admits a new word.
  always @(negedge clk) begin
    logic expReady;
    expReady = !flush && ((expQ.size() < DEPTH) || out_ready);
    checkOutput("count", 64'(count), 64'(expQ.size()));
    checkOutput("in_ready", 64'(in_ready), 64'(expReady));
    if (expQ.size() == 0) checkOutput("no_phantom_word", 64'(out_valid), 64'(0));
    else if (out_valid) checkOutput("out_data", 64'(out_data), 64'(expQ[0]));
    if (!out_valid) checkOutput("out_data_hold", 64'(out_data), 64'(lastOut));
    else if (expQ.size() != 0) lastOut = expQ[0];
    if (rst) begin
      if (flush) begin
        expQ.delete();
      end else begin
        if (out_valid && out_ready) begin
          outCycles.push_back(cycleCnt);
          if (expQ.size() != 0) void'(expQ.pop_front());
        end
        if (in_valid && expReady) expQ.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] w);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!acc) recordFail("accept_timeout");
  endtask

  task automatic drain();
    int k;
    k         = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (expQ.size() != 0 && k < 50) begin
      step();
      k++;
    end
    if (expQ.size() != 0) recordFail("drain_timeout");
    repeat (2) step();
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_out_data", 64'(out_data), 64'(0));
    checkOutput("reset_count", 64'(count), 64'(0));
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    #18 rst = 1'b1;
    step();

    $display("[TB] single word");
    out_ready = 1'b1;
    outCycles.delete();
    startCycle = cycleCnt;
    applyStimulus(4'b1010);
    idle(8);
    checkOutput("single_out_count", 64'(outCycles.size()), 64'(1));
    if (outCycles.size() >= 1) checkOutput("single_latency", 64'(outCycles[0] - startCycle), 64'(DEPTH));

    $display("[TB] streaming");
    outCycles.delete();
    startCycle = cycleCnt;
    for (int w = 0; w < 8; w++) applyStimulus(WIDTH'(w));
    idle(8);
    checkOutput("stream_out_count", 64'(outCycles.size()), 64'(8));
    if (outCycles.size() == 8) begin
      checkOutput("stream_latency", 64'(outCycles[0] - startCycle), 64'(DEPTH));
      checkOutput("stream_span", 64'(outCycles[7] - outCycles[0]), 64'(7));
    end

    $display("[TB] stall and fill");
    out_ready = 1'b0;
    fork
      begin
        for (int w = 1; w <= 6; w++) applyStimulus(WIDTH'(w));
      end
      begin
        repeat (7) @(posedge clk);
        #1;
        checkOutput("stall_count", 64'(count), 64'(DEPTH));
        checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] bubble collapse");
    out_ready = 1'b0;
    applyStimulus(4'h5);
    idle(2);
    applyStimulus(4'h6);
    idle(4);
    checkOutput("bubble_v3", 64'(dut.valid_q[3]), 64'(1));
    checkOutput("bubble_v2", 64'(dut.valid_q[2]), 64'(1));
    checkOutput("bubble_v1", 64'(dut.valid_q[1]), 64'(0));
    checkOutput("bubble_count", 64'(count), 64'(2));

    $display("[TB] flush");
    applyStimulus(4'h9);
    checkOutput("preflush_count", 64'(count), 64'(3));
    in_valid = 1'b1;
    in_data  = 4'hF;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_count", 64'(count), 64'(0));
    checkOutput("flush_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    idle(6);

    $display("[TB] async reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(4'h3);
    applyStimulus(4'h7);
    checkOutput("prereset_count", 64'(count), 64'(2));
    #1 rst = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset_out_data", 64'(out_data), 64'(0));
    checkOutput("midreset_count", 64'(count), 64'(0));
    expQ.delete();
    lastOut = '0;
    step();
    step();
    rst = 1'b1;
    step();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      out_ready = (n % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    flush = 1'b0;
    drain();
    checkOutput("final_count", 64'(count), 64'(0));
    checkOutput("final_out_valid", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
